// File: rtl/sample_stream_player.sv
// Playback source: samples loaded over a write port, then streamed from RAM over valid/ready
// in one-shot or loop mode, with a programmable pass length and inter-sample gap.
module sample_stream_player #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8000,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned GAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   len,
    input  logic [GAP_W-1:0]  rate_div,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              wrap,
    output logic              done
);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    if (DEPTH < 2 || (64'(1) << ADDR_W) < 64'(DEPTH)) begin : g_bad_params
        $error("sample_stream_player: DEPTH must be >= 2 and fit in ADDR_W bits");
    end

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHOW, S_GAP} state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [LEN_W-1:0]  len_q;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ADDR_W-1:0] rd_addr;

    logic accept_c;
    logic last_c;
    logic launch_c;
    logic valid_d;
    logic busy_d;
    logic done_d;
    logic wrap_d;

    // A transfer that coincides with stop is not delivered.
    assign accept_c = (state == S_SHOW) && out_ready && !stop;
    assign last_c   = ({1'b0, rd_addr} == (len_q - LEN_W'(1)));
    assign launch_c = (state == S_IDLE) && start && !stop && (len != '0);

    // Write port: out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // loop_en is looked at live on the last sample so it can end playback after this pass.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (launch_c) state_nx = S_FETCH;
            S_FETCH: state_nx = S_SHOW;
            S_SHOW: begin
                if (out_ready) begin
                    if (last_c && !loop_en) begin
                        state_nx = S_IDLE;
                    end else if (gap_q == '0) begin
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_GAP;
                    end
                end
            end
            S_GAP:   if (gap_cnt <= GAP_W'(1)) state_nx = S_FETCH;
            default: state_nx = S_IDLE;
        endcase
        if (stop) begin
            state_nx = S_IDLE;
        end
    end

    always_comb begin
        valid_d = (state_nx == S_SHOW);
        busy_d  = (state_nx != S_IDLE);
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (accept_c && last_c) begin
            done_d = !loop_en;
            wrap_d = loop_en;
        end
    end

    // Output registers and playback datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            rd_addr   <= '0;
        end else begin
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            wrap      <= wrap_d;
            if (launch_c) begin
                len_q   <= (len > DEPTH_L) ? DEPTH_L : len;
                gap_q   <= rate_div;
                rd_addr <= '0;
            end
            if (state == S_FETCH) begin
                out_data <= mem[rd_addr];
                out_addr <= rd_addr;
            end
            if (accept_c) begin
                rd_addr <= last_c ? '0 : rd_addr + ADDR_W'(1);
                if (state_nx == S_GAP) begin
                    gap_cnt <= gap_q;
                end
            end
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end
endmodule
